time_display_scan: RTL and testbench

Consumer of the stopwatch core's binary hh/mm/ss outputs. Snapshots the time once per display frame and converts each field to two BCD digits with a sequential subtract-by-10 engine. Drives a 6-digit multiplexed, active-low common-anode 7-segment display with a blinking separator. Sits between the timekeeping core and board pins on the ETRI050 MPW top.

---
 rtl/time_disp_pkg.sv | 18 +
 rtl/seg7_decode.sv | 24 ++
 rtl/time_display_scan.sv | 113 +++++++++++
 tb/tb_time_display_scan.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/time_disp_pkg.sv
// time_disp_pkg: shared FSM state, segment codes and field limits for the time display scanner
package time_disp_pkg;
  typedef enum logic [2:0] {SNAP, CONV_H, CONV_M, CONV_S, SHOW} state_t;
  localparam logic [6:0] SEG_0    = 7'h40;
  localparam logic [6:0] SEG_1    = 7'h79;
  localparam logic [6:0] SEG_2    = 7'h24;
  localparam logic [6:0] SEG_3    = 7'h30;
  localparam logic [6:0] SEG_4    = 7'h19;
  localparam logic [6:0] SEG_5    = 7'h12;
  localparam logic [6:0] SEG_6    = 7'h02;
  localparam logic [6:0] SEG_7    = 7'h78;
  localparam logic [6:0] SEG_8    = 7'h00;
  localparam logic [6:0] SEG_9    = 7'h10;
  localparam logic [6:0] SEG_DASH = 7'h3F;
  localparam logic [6:0] SEG_OFF  = 7'h7F;
  localparam logic [7:0] HH_MAX   = 8'd23;
  localparam logic [7:0] MS_MAX   = 8'd59;
endpackage

// File: rtl/seg7_decode.sv
// seg7_decode: BCD digit plus dash flag to active-low gfedcba segments
//   digit : 4-bit BCD value (codes above 9 blank the digit)
//   dash  : overrides the digit with a centre bar
//   seg_n : active-low segments, bit0=a .. bit6=g
module seg7_decode
  import time_disp_pkg::*;
(
  input  logic [3:0] digit,
  input  logic       dash,
  output logic [6:0] seg_n
);
  always_comb
    seg_n = dash          ? SEG_DASH :
            digit == 4'd0 ? SEG_0 :
            digit == 4'd1 ? SEG_1 :
            digit == 4'd2 ? SEG_2 :
            digit == 4'd3 ? SEG_3 :
            digit == 4'd4 ? SEG_4 :
            digit == 4'd5 ? SEG_5 :
            digit == 4'd6 ? SEG_6 :
            digit == 4'd7 ? SEG_7 :
            digit == 4'd8 ? SEG_8 :
            digit == 4'd9 ? SEG_9 : SEG_OFF;
endmodule

// File: rtl/time_display_scan.sv
// time_display_scan: per-frame hh/mm/ss snapshot, BCD conversion and 6-digit 7-segment scan
//   ap_clk, ap_rst_n : clock, asynchronous active-low reset
//   hh, mm, ss       : binary time fields (illegal values shown as dashes)
//   blank            : forces all digit enables off while scanning continues
//   seg_n, an_n, dp_n: active-low segments, digit enables and separator
//   valid            : sticky once the first conversion has landed
//   frame_done       : one-cycle pulse as the digit index wraps 5->0
module time_display_scan
  import time_disp_pkg::*;
#(
  parameter int SCAN_DIV = 1000
) (
  input  logic       ap_clk,
  input  logic       ap_rst_n,
  input  logic [7:0] hh,
  input  logic [7:0] mm,
  input  logic [7:0] ss,
  input  logic       blank,
  output logic [6:0] seg_n,
  output logic [5:0] an_n,
  output logic       dp_n,
  output logic       valid,
  output logic       frame_done
);
  localparam int PW = $clog2(SCAN_DIV);
  state_t          state;
  logic [PW-1:0]   presc;
  logic [2:0]      idx;
  logic [7:0]      snap_h, snap_m, snap_s, work, fld, lim, nxt;
  logic [3:0]      tens;
  logic [5:0][3:0] cv, cv_nx, disp;
  logic [2:0]      cv_dash, dash_nx, disp_dash;
  logic [1:0]      f;
  logic [6:0]      seg_cur;
  logic            sep_off, tick, bad, done;
  seg7_decode u_dec (
    .digit (disp[idx]),
    .dash  (disp_dash[idx[2:1]]),
    .seg_n (seg_cur)
  );
  // f selects the digit pair of the field being converted: 2=hh, 1=mm, 0=ss
  always_comb begin
    tick    = presc == PW'(SCAN_DIV - 1);
    f       = state == CONV_H ? 2'd2 : state == CONV_M ? 2'd1 : 2'd0;
    fld     = state == CONV_H ? snap_h : state == CONV_M ? snap_m : snap_s;
    lim     = state == CONV_H ? HH_MAX : MS_MAX;
    nxt     = state == CONV_H ? snap_m : snap_s;
    bad     = fld > lim;
    done    = bad || work < 8'd10;
    cv_nx   = cv;
    cv_nx[{f, 1'b0}] = bad ? 4'd0 : work[3:0];
    cv_nx[{f, 1'b1}] = bad ? 4'd0 : tens;
    dash_nx    = cv_dash;
    dash_nx[f] = bad;
  end
  always_ff @(posedge ap_clk or negedge ap_rst_n)
    if (!ap_rst_n) begin
      state      <= SNAP;
      presc      <= '0;
      idx        <= '0;
      frame_done <= 1'b0;
      valid      <= 1'b0;
      seg_n      <= SEG_OFF;
      an_n       <= 6'h3F;
      dp_n       <= 1'b1;
      snap_h     <= '0;
      snap_m     <= '0;
      snap_s     <= '0;
      work       <= '0;
      tens       <= '0;
      cv         <= '0;
      cv_dash    <= '0;
      disp       <= '0;
      disp_dash  <= '0;
      sep_off    <= 1'b1;
    end else begin
      presc      <= tick ? '0 : presc + PW'(1);
      idx        <= !tick ? idx : idx == 3'd5 ? 3'd0 : idx + 3'd1;
      frame_done <= tick && idx == 3'd5;
      seg_n      <= seg_cur;
      an_n       <= valid && !blank ? ~(6'b1 << idx) : 6'h3F;
      dp_n       <= !((idx == 3'd2 || idx == 3'd4) && !sep_off);
      case (state)
        SNAP: begin
          snap_h <= hh;
          snap_m <= mm;
          snap_s <= ss;
          work   <= hh;
          tens   <= '0;
          state  <= CONV_H;
        end
        CONV_H, CONV_M, CONV_S:
          if (!done) begin
            work <= work - 8'd10;
            tens <= tens + 4'd1;
          end else begin
            cv      <= cv_nx;
            cv_dash <= dash_nx;
            work    <= nxt;
            tens    <= '0;
            state   <= state == CONV_H ? CONV_M : state == CONV_M ? CONV_S : SHOW;
            // display registers only ever change here, so a frame never shows mixed snapshots
            if (state == CONV_S) begin
              disp      <= cv_nx;
              disp_dash <= dash_nx;
              sep_off   <= snap_s[0];
              valid     <= 1'b1;
            end
          end
        default: if (frame_done) state <= SNAP;
      endcase
    end
endmodule

// File: tb/tb_time_display_scan.sv
// tb_time_display_scan: table-driven check of digit scan, BCD conversion, blanking and reset
module tb_time_display_scan;
  localparam int SD = 32;
  logic       ap_clk = 1'b0;
  logic       ap_rst_n = 1'b0;
  logic       blank = 1'b0;
  logic [7:0] hh = '0, mm = '0, ss = '0;
  logic [6:0] seg_n;
  logic [5:0] an_n;
  logic       dp_n, valid, frame_done;
  int         errors = 0;
  int         checks = 0;
  typedef struct {
    logic [7:0]      hh, mm, ss;
    logic [5:0][6:0] seg;
    logic [5:0]      dp;
  } vec_t;
  vec_t tv [6];

  time_display_scan #(.SCAN_DIV(SD)) dut (
    .ap_clk     (ap_clk),
    .ap_rst_n   (ap_rst_n),
    .hh         (hh),
    .mm         (mm),
    .ss         (ss),
    .blank      (blank),
    .seg_n      (seg_n),
    .an_n       (an_n),
    .dp_n       (dp_n),
    .valid      (valid),
    .frame_done (frame_done)
  );

  always #5 ap_clk = ~ap_clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_frame();
    int n = 0;
    do begin
      @(posedge ap_clk);
      #1;
      n++;
    end while (!frame_done && n < 400);
    chk("frame_done seen", 32'(frame_done), 32'd1);
  endtask

  task automatic check_frame(input vec_t v, input bit blk);
    int w = 0;
    logic [5:0] an_exp;
    for (int i = 0; i < 6; i++) begin
      repeat (SD * i + 20 - w) @(posedge ap_clk);
      w = SD * i + 20;
      #1;
      an_exp = blk ? 6'h3F : ~(6'b1 << i);
      chk($sformatf("seg idx%0d %0d:%0d:%0d", i, v.hh, v.mm, v.ss), 32'(seg_n), 32'(v.seg[i]));
      chk($sformatf("an idx%0d %0d:%0d:%0d", i, v.hh, v.mm, v.ss), 32'(an_n), 32'(an_exp));
      chk($sformatf("dp idx%0d %0d:%0d:%0d", i, v.hh, v.mm, v.ss), 32'(dp_n), 32'(v.dp[i]));
    end
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, " seg_n"}, 32'(seg_n), 32'h7F);
    chk({tag, " an_n"}, 32'(an_n), 32'h3F);
    chk({tag, " dp_n"}, 32'(dp_n), 32'd1);
    chk({tag, " valid"}, 32'(valid), 32'd0);
    chk({tag, " frame_done"}, 32'(frame_done), 32'd0);
  endtask

  initial begin
    int n;
    tv[0] = '{8'd12, 8'd34, 8'd56, {7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02}, 6'b101011};
    tv[1] = '{8'd24, 8'd60, 8'd5,  {7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h40, 7'h12}, 6'b111111};
    tv[2] = '{8'd23, 8'd59, 8'd59, {7'h24, 7'h30, 7'h12, 7'h10, 7'h12, 7'h10}, 6'b111111};
    tv[3] = '{8'd0,  8'd0,  8'd0,  {7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40}, 6'b101011};
    tv[4] = '{8'd9,  8'd10, 8'd255,{7'h40, 7'h10, 7'h79, 7'h40, 7'h3F, 7'h3F}, 6'b111111};
    tv[5] = '{8'd12, 8'd34, 8'd57, {7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h78}, 6'b111111};
    repeat (3) @(posedge ap_clk);
    #1;
    check_reset_values("reset hold");
    #2 ap_rst_n = 1'b1;
    n = 0;
    do begin
      @(posedge ap_clk);
      #1;
      n++;
    end while (!valid && n < 20);
    chk("valid within 20 clocks", 32'(valid), 32'd1);
    repeat (3) @(posedge ap_clk);
    #1;
    chk("first digit seg", 32'(seg_n), 32'h40);
    chk("first digit an", 32'(an_n), 32'h3E);
    for (int k = 0; k < 5; k++) begin
      hh = tv[k].hh;
      mm = tv[k].mm;
      ss = tv[k].ss;
      wait_frame();
      check_frame(tv[k], 1'b0);
    end
    wait_frame();
    n = 0;
    do begin
      @(posedge ap_clk);
      #1;
      n++;
    end while (!frame_done && n < 400);
    chk("frame period", 32'(n), 32'd192);
    hh = 8'd12;
    mm = 8'd34;
    ss = 8'd56;
    wait_frame();
    repeat (10) @(posedge ap_clk);
    #1 ss = 8'd57;
    repeat (10) @(posedge ap_clk);
    #1;
    chk("mid-frame change ignored", 32'(seg_n), 32'h02);
    wait_frame();
    check_frame(tv[5], 1'b0);
    wait_frame();
    blank = 1'b1;
    check_frame(tv[5], 1'b1);
    wait_frame();
    repeat (69) @(posedge ap_clk);
    #1 blank = 1'b0;
    repeat (2) @(posedge ap_clk);
    #1;
    chk("unblank an at idx2", 32'(an_n), 32'h3B);
    chk("unblank seg at idx2", 32'(seg_n), 32'h19);
    hh = 8'd23;
    mm = 8'd59;
    ss = 8'd59;
    wait_frame();
    repeat (7) @(posedge ap_clk);
    #2 ap_rst_n = 1'b0;
    #1;
    check_reset_values("reset during conversion");
    ap_rst_n = 1'b1;
    check_frame(tv[2], 1'b0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
